// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side pointer controller
// Binary/Gray write pointers, fill level, almost-full and sticky overflow.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_full,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  input  logic                  clr_overflow,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray_next,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_almost_full,
  output logic                  wr_overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] fill_next;
  logic          wr_inc;

  assign wr_inc           = wr_en & ~wr_full & ~rst;
  assign mem_wr_en        = wr_inc;
  assign wr_bin_next      = wr_bin + PW'(wr_inc);
  assign wr_ptr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
  assign wr_addr          = wr_bin[ADDR_WIDTH-1:0];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PW; i++) begin
      rd_bin[i] = ^(rd_ptr_gray_sync >> i);
    end
  end

  // Uses the post-write pointer against a lagging read pointer, so it can only over-report.
  assign fill_next = wr_bin_next - rd_bin;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_bin         <= '0;
      wr_ptr_gray    <= '0;
      wr_level       <= '0;
      wr_almost_full <= 1'b0;
      wr_overflow    <= 1'b0;
    end else begin
      wr_bin         <= wr_bin_next;
      wr_ptr_gray    <= wr_ptr_gray_next;
      wr_level       <= fill_next;
      wr_almost_full <= (fill_next >= AF_LVL);
      if (wr_en && wr_full) begin
        wr_overflow <= 1'b1;
      end else if (clr_overflow) begin
        wr_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - self-checking bench for fifo_wr_ctrl
// Counts-based reference model with a behavioural full detector.
module tb_fifo_wr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MODP  = 32;
  localparam int AF    = 12;

  logic          wr_clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          wr_full = 1'b0;
  logic [AW:0]   rd_ptr_gray_sync = '0;
  logic          clr_overflow = 1'b0;
  logic [AW:0]   wr_ptr_gray_next;
  logic [AW:0]   wr_ptr_gray;
  logic [AW-1:0] wr_addr;
  logic          mem_wr_en;
  logic [AW:0]   wr_level;
  logic          wr_almost_full;
  logic          wr_overflow;

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(AF)) dut (
    .wr_clk(wr_clk), .rst(rst), .wr_en(wr_en), .wr_full(wr_full),
    .rd_ptr_gray_sync(rd_ptr_gray_sync), .clr_overflow(clr_overflow),
    .wr_ptr_gray_next(wr_ptr_gray_next), .wr_ptr_gray(wr_ptr_gray),
    .wr_addr(wr_addr), .mem_wr_en(mem_wr_en), .wr_level(wr_level),
    .wr_almost_full(wr_almost_full), .wr_overflow(wr_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: writes accepted (mod 32), reads done (mod 32), flags.
  int m_wr = 0, m_rd = 0, m_level = 0;
  bit m_af = 0, m_ovf = 0, m_full = 0;

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = 5'(n % MODP);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit we, input bit clr, input bit chk);
    bit inc;
    int nxt, diff;
    @(negedge wr_clk);
    rst = r; wr_en = we; clr_overflow = clr; wr_full = m_full;
    rd_ptr_gray_sync = gray(m_rd);
    inc  = we && !m_full && !r;
    nxt  = (m_wr + (inc ? 1 : 0)) % MODP;
    diff = (nxt - m_rd + MODP) % MODP;
    #1;
    if (chk) begin
      check("mem_wr_en", 32'(mem_wr_en), 32'(inc));
      check("gray_next", 32'(wr_ptr_gray_next), 32'(gray(nxt)));
      check("wr_addr",   32'(wr_addr),   32'(m_wr % DEPTH));
    end
    @(posedge wr_clk);
    if (r) begin
      m_wr = 0; m_rd = 0; m_level = 0; m_af = 0; m_ovf = 0; m_full = 0;
    end else begin
      m_wr    = nxt;
      m_level = diff;
      m_af    = (diff >= AF);
      if (we && m_full) m_ovf = 1;
      else if (clr)     m_ovf = 0;
      m_full  = (diff == DEPTH);
    end
    #1;
    if (chk) begin
      check("wr_ptr_gray",    32'(wr_ptr_gray),    32'(gray(m_wr)));
      check("wr_level",       32'(wr_level),       32'(m_level));
      check("wr_almost_full", 32'(wr_almost_full), 32'(m_af));
      check("wr_overflow",    32'(wr_overflow),    32'(m_ovf));
    end
  endtask

  logic [AW:0] prev_gray;

  initial begin
    // Reset with writes requested: nothing may be written.
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    check("rst_gray_next_zero", 32'(wr_ptr_gray_next), 32'(5'b00000));
    check("rst_level_zero", 32'(wr_level), 32'd0);

    // Fill with reader stalled.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, 1);
      if (i == AF - 1) check("af_rises_at_12", 32'(wr_almost_full), 32'd1);
      if (i == AF - 2) check("af_low_at_11", 32'(wr_almost_full), 32'd0);
    end
    check("fill_level", 32'(wr_level), 32'd16);
    check("fill_gray", 32'(wr_ptr_gray), 32'(5'b11000));

    // Writes while full are rejected and flagged.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
    check("ovf_set", 32'(wr_overflow), 32'd1);
    check("ovf_ptr_held", 32'(wr_ptr_gray), 32'(5'b11000));
    step(0, 0, 1, 1);
    check("ovf_cleared", 32'(wr_overflow), 32'd0);
    step(0, 1, 1, 1);
    check("ovf_set_beats_clr", 32'(wr_overflow), 32'd1);
    step(0, 0, 1, 1);

    // Wrap: reader keeps pace, 32 writes.
    step(1, 0, 0, 1);
    prev_gray = wr_ptr_gray;
    for (int i = 0; i < MODP; i++) begin
      m_rd = m_wr;
      step(0, 1, 0, 1);
      check("gray_one_bit", 32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
      prev_gray = wr_ptr_gray;
    end
    check("wrap_gray_zero", 32'(wr_ptr_gray), 32'd0);
    check("wrap_addr_zero", 32'(wr_addr), 32'd0);

    // Reset mid-operation.
    step(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1);
    check("mid_gray_00111", 32'(wr_ptr_gray), 32'(5'b00111));
    step(1, 1, 0, 1);
    check("mid_rst_gray", 32'(wr_ptr_gray), 32'd0);
    check("mid_rst_level", 32'(wr_level), 32'd0);

    // Randomized traffic with a reader that advances only over written data.
    for (int i = 0; i < 3000; i++) begin
      bit r, we, clr;
      r   = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 9) == 0);
      if (((m_wr - m_rd + MODP) % MODP) > 0 && $urandom_range(0, 9) < 4)
        m_rd = (m_rd + 1) % MODP;
      step(r, we, clr, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Write-side pointer controller of the async FIFO; clocked by `wr_clk`.
- Gates write requests with the registered full flag and drives write address/enable to the dual-port RAM.
- Maintains binary and Gray write pointers. Its combinational `wr_ptr_gray_next` feeds the full detector, which returns `wr_full`.
- Also produces fill level, almost-full, and a sticky overflow error flag.

Parameters:
- `ADDR_WIDTH`, 4, RAM address bits; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `AF_THRESH`, 12, almost-full asserts when level >= AF_THRESH; legal range 1..2^ADDR_WIDTH.

Ports:
- `wr_clk`  in  1  write-domain clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write request from producer.
- `wr_full`  in  1  registered full flag from full detector.
- `rd_ptr_gray_sync`  in  ADDR_WIDTH+1  read Gray pointer, already synchronized into `wr_clk`.
- `clr_overflow`  in  1  clears `wr_overflow`.
- `wr_ptr_gray_next`  out  ADDR_WIDTH+1  combinational next Gray write pointer (to full detector).
- `wr_ptr_gray`  out  ADDR_WIDTH+1  registered Gray write pointer (to read-domain synchronizer).
- `wr_addr`  out  ADDR_WIDTH  RAM write address.
- `mem_wr_en`  out  1  RAM write strobe, combinational.
- `wr_level`  out  ADDR_WIDTH+1  registered fill level, write-domain view.
- `wr_almost_full`  out  1  registered almost-full.
- `wr_overflow`  out  1  sticky overflow error.

Behaviour:
- Clock and reset: one clock, `wr_clk`. Reset `rst` is synchronous and active-high. While `rst`=1 at a rising edge, all registers load 0:
  - `wr_bin`, `wr_ptr_gray`, `wr_level`, `wr_almost_full`, `wr_overflow` = 0.
- Write qualification:
  - `wr_inc` = `wr_en` & ~`wr_full` & ~`rst`.
  - `mem_wr_en` = `wr_inc`.
  - While `rst`=1: `mem_wr_en`=0 and `wr_ptr_gray_next` = Gray(`wr_bin`).
- Pointer arithmetic, widths ADDR_WIDTH+1, modulo 2^(ADDR_WIDTH+1):
  - `wr_bin_next` = `wr_bin` + `wr_inc`.
  - `wr_ptr_gray_next` = `wr_bin_next` ^ (`wr_bin_next` >> 1), combinational, zero latency.
  - On a clock edge: `wr_bin` <= `wr_bin_next` and `wr_ptr_gray` <= `wr_ptr_gray_next`.
  - `wr_addr` = `wr_bin[ADDR_WIDTH-1:0]`: the current pointer, i.e. the address written this cycle.
  - Wrap: binary 2^(ADDR_WIDTH+1)-1 -> 0, with no stall and no glitch. Gray changes exactly one bit per increment.
- Level:
  - `rd_bin` = Gray-to-binary of `rd_ptr_gray_sync` (MSB-down XOR prefix), combinational.
  - `wr_level` <= (`wr_bin_next` - `rd_bin`) mod 2^(ADDR_WIDTH+1). Range 0..2^ADDR_WIDTH.
  - `wr_level` is pessimistic: it may over-report by the synchronizer lag. It must never under-report.
- Almost full: `wr_almost_full` <= ((`wr_bin_next` - `rd_bin`) >= AF_THRESH). Same cycle as `wr_level` update.
- Full timing:
  - `wr_full` is the full detector's registered compare of `wr_ptr_gray_next`. It is high in the cycle after the write that fills the FIFO.
  - This block relies on that; no write is accepted in any cycle where `wr_full`=1.
- Overflow, sticky:
  - Set condition: `wr_en` & `wr_full`.
  - If the set condition holds: `wr_overflow` <= 1. Set wins over `clr_overflow` in the same cycle.
  - Else if `clr_overflow`=1: `wr_overflow` <= 0.
  - Else hold.
  - A rejected write changes no pointer, level or RAM contents.
- Reset mid-operation: pointers return to 0 on the next edge regardless of `wr_en` or `wr_full`; no RAM write occurs in the reset cycle. Read-domain reset is coordinated externally.
- No X propagation: all outputs are defined every cycle after the first reset edge.

Test Plan:
- Reset: hold `rst`=1 for 2 cycles with `wr_en`=1 -> `mem_wr_en`=0, all outputs 0, `wr_ptr_gray_next`=00000.
- Fill (ADDR_WIDTH=4), `rd_ptr_gray_sync`=00000:
  - Drive `wr_en`=1 for 16 cycles -> `wr_addr` runs 0..15 and `wr_ptr_gray` sequence 00000, 00001, 00011, 00010, …
  - After the 16th write, `wr_ptr_gray_next`=11000; the detector model returns `wr_full`=1 and `wr_level`=16.
  - `wr_almost_full` rises on the edge where level becomes 12.
- Overflow: FIFO full, `wr_en`=1 for 3 cycles -> `mem_wr_en`=0, `wr_bin` stays 16, `wr_overflow`=1. Pulse `clr_overflow` with `wr_en`=0 -> `wr_overflow`=0.
- Clear versus set: `clr_overflow`=1 together with `wr_en`=1 while `wr_full`=1 -> `wr_overflow` remains 1.
- Wrap-around:
  - Advance the read Gray pointer in step with writes; perform 32 writes.
  - `wr_bin` goes 31 -> 0 and `wr_ptr_gray` goes 10000 -> 00000.
  - `wr_addr` goes 15 -> 0; exactly one Gray bit toggles per write throughout.
- Reset mid-operation: after 5 writes (`wr_ptr_gray`=00111), assert `rst` together with `wr_en`=1 -> next edge gives all pointers 0, no `mem_wr_en` that cycle, and `wr_level`=0.
